// File: rtl/fifo_arb_pkg.sv
// Shared types, default parameters and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 256;

  // Ceiling log2, usable in parameter context.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate from last_i+1, first valid requester wins; optional
// strict priority for requester 0, which then sits outside the rotation.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter bit          PRIO_EN = 1'b0,
  localparam int unsigned IDXW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDXW-1:0] last_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_c_o,
  output logic [IDXW-1:0] idx_c_o,
  output logic            any_c_o
);

  always_comb begin
    logic            found;
    int unsigned     cand;
    logic [IDXW-1:0] cand_idx;
    grant_c_o = '0;
    idx_c_o   = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (en_i) begin
      if (PRIO_EN && valid_i[0]) begin
        grant_c_o[0] = 1'b1;
        found        = 1'b1;
      end else begin
        for (int unsigned k = 1; k <= NREQ; k++) begin
          cand     = (32'(last_i) + k) % NREQ;
          cand_idx = IDXW'(cand);
          if (!found && valid_i[cand_idx] && !(PRIO_EN && cand == 0)) begin
            grant_c_o[cand_idx] = 1'b1;
            idx_c_o             = cand_idx;
            found               = 1'b1;
          end
        end
      end
    end
    any_c_o = found;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the single FIFO write port with occupancy tracking,
// backpressure and flush sequencing. Define FIFO_ARB_PRIORITY_EN for strict
// priority on requester 0.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned LVLW = clog2(DEPTH),
  localparam int unsigned IDXW = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      fifo_write_data,
  output logic                  fifo_write_strobe,
  input  logic                  fifo_read_strobe,
  output logic                  fifo_clear,
  output logic [LVLW-1:0]       level,
  output logic                  full,
  output logic                  underflow,
  output logic [IDXW-1:0]       grant_id
);

`ifdef FIFO_ARB_PRIORITY_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [LVLW-1:0] LVL_MAX = LVLW'(DEPTH - 1);

  arb_state_e       state_q, state_d;
  logic [LVLW-1:0]  level_q, level_d;
  logic             uf_q, uf_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic [IDXW-1:0]  gid_q, gid_d;
  logic             wstb_q, wstb_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             clear_q, clear_d;

  logic             accept_en;
  logic [NREQ-1:0]  pick_grant;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any;
  logic             rd_ok;
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // No grant while in reset, flushing, or at capacity.
  assign accept_en = !reset && (state_q == ST_RUN) && !flush && (level_q < LVL_MAX);

  rr_pick #(
    .NREQ    (NREQ),
    .PRIO_EN (PRIO_EN)
  ) u_pick (
    .valid_i   (req_valid),
    .last_i    (last_q),
    .en_i      (accept_en),
    .grant_c_o (pick_grant),
    .idx_c_o   (pick_idx),
    .any_c_o   (pick_any)
  );

  assign rd_ok = fifo_read_strobe && (level_q != '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    uf_d    = uf_q;
    last_d  = last_q;
    gid_d   = gid_q;
    wstb_d  = 1'b0;
    wdata_d = wdata_q;
    clear_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (pick_any) begin
          wstb_d  = 1'b1;
          wdata_d = data_arr[pick_idx];
          gid_d   = pick_idx;
          if (!(PRIO_EN && pick_idx == '0)) last_d = pick_idx;
        end
        if (fifo_read_strobe && level_q == '0) uf_d = 1'b1;
        if (pick_any && !rd_ok) begin
          level_d = level_q + LVLW'(1);
        end else if (!pick_any && rd_ok) begin
          level_d = level_q - LVLW'(1);
        end
        if (flush) begin
          state_d = ST_FLUSH;
          clear_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        level_d = '0;
        uf_d    = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Last grant resets to NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      level_q <= '0;
      uf_q    <= 1'b0;
      last_q  <= IDXW'(NREQ - 1);
      gid_q   <= '0;
      wstb_q  <= 1'b0;
      wdata_q <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      uf_q    <= uf_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      wstb_q  <= wstb_d;
      wdata_q <= wdata_d;
      clear_q <= clear_d;
    end
  end

  assign req_ready         = pick_grant;
  assign full              = (level_q == LVL_MAX);
  assign level             = level_q;
  assign underflow         = uf_q;
  assign grant_id          = gid_q;
  assign fifo_write_strobe = wstb_q;
  assign fifo_write_data   = wdata_q;
  assign fifo_clear        = clear_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a behavioural occupancy/arbitration model.
module tb_fifo_write_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVLW  = 3;
  localparam int unsigned IDXW  = 2;

`ifdef FIFO_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  flush;
  logic [WIDTH-1:0]      fifo_write_data;
  logic                  fifo_write_strobe;
  logic                  fifo_read_strobe;
  logic                  fifo_clear;
  logic [LVLW-1:0]       level;
  logic                  full;
  logic                  underflow;
  logic [IDXW-1:0]       grant_id;

  fifo_write_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .flush             (flush),
    .fifo_write_data   (fifo_write_data),
    .fifo_write_strobe (fifo_write_strobe),
    .fifo_read_strobe  (fifo_read_strobe),
    .fifo_clear        (fifo_clear),
    .level             (level),
    .full              (full),
    .underflow         (underflow),
    .grant_id          (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int         m_level;
  int         m_last;
  int         m_gid;
  bit         m_uf;
  bit         m_flushst;
  bit         m_clear;
  bit         m_stb;
  logic [7:0] m_data;
  logic [7:0] dat [NREQ];
  logic [NREQ-1:0] obs_ready;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level   = 0;
    m_last    = NREQ - 1;
    m_gid     = 0;
    m_uf      = 0;
    m_flushst = 0;
    m_clear   = 0;
    m_stb     = 0;
    m_data    = 8'h00;
  endtask

  // Which requester the rules say gets ready this cycle, -1 for none.
  function automatic int exp_pick(input logic [NREQ-1:0] v, input bit fl);
    if (reset || m_flushst || fl || m_level >= DEPTH - 1) return -1;
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= NREQ; k++) begin
      int c = (m_last + k) % NREQ;
      if (PRIO && c == 0) continue;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input logic [NREQ-1:0] v, input bit fl, input bit rd);
    int p;
    req_valid        = v;
    flush            = fl;
    fifo_read_strobe = rd;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
    #1;
    p = exp_pick(v, fl);
    obs_ready = req_ready;
    chk("req_ready", int'(req_ready), (p < 0) ? 0 : (1 << p));
    chk("level", int'(level), m_level);
    chk("full", int'(full), int'(m_level == DEPTH - 1));
    chk("underflow", int'(underflow), int'(m_uf));
    chk("grant_id", int'(grant_id), m_gid);
    chk("wr_strobe", int'(fifo_write_strobe), int'(m_stb));
    chk("wr_data", int'(fifo_write_data), int'(m_data));
    chk("fifo_clear", int'(fifo_clear), int'(m_clear));
    if (m_flushst) begin
      m_level   = 0;
      m_uf      = 0;
      m_flushst = 0;
      m_clear   = 0;
      m_stb     = 0;
    end else begin
      m_stb = (p >= 0);
      if (p >= 0) begin
        m_data = dat[p];
        m_gid  = p;
        if (!(PRIO && p == 0)) m_last = p;
      end
      if (rd) begin
        if (m_level == 0) m_uf = 1;
        else m_level--;
      end
      if (p >= 0) m_level++;
      m_flushst = fl;
      m_clear   = fl;
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    req_valid        = '1;
    req_data         = '0;
    flush            = 1'b0;
    fifo_read_strobe = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) dat[i] = 8'(8'h10 + i);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready_held", int'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk("rst_level", int'(level), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_strobe", int'(fifo_write_strobe), 0);
    chk("rst_data", int'(fifo_write_data), 0);
    chk("rst_clear", int'(fifo_clear), 0);
    chk("rst_underflow", int'(underflow), 0);

    // All valid: rotation 0,1,2,3,0 with data 0x10..0x13
    for (int k = 0; k < 5; k++) begin
      step('1, 1'b0, 1'b0);
      chk("rr_seq", int'(obs_ready), PRIO ? 1 : (1 << (k % 4)));
      chk("rr_strobe", int'(fifo_write_strobe), 1);
      chk("rr_data", int'(fifo_write_data), PRIO ? 16 : 16 + (k % 4));
    end
    chk("lvl_after5", int'(level), 5);

    // Accept and read together at level 5
    step('1, 1'b0, 1'b1);
    chk("acc_rd_ready", int'(obs_ready), PRIO ? 1 : 2);
    chk("acc_rd_level", int'(level), 5);
    step('0, 1'b0, 1'b1);
    chk("rd_level", int'(level), 4);

    // Flush at level 4 with requesters valid
    step('1, 1'b1, 1'b0);
    chk("flush_cyc_ready", int'(obs_ready), 0);
    chk("flush_clear_hi", int'(fifo_clear), 1);
    step('1, 1'b0, 1'b0);
    chk("flush_st_ready", int'(obs_ready), 0);
    chk("flush_clear_lo", int'(fifo_clear), 0);
    chk("flush_level", int'(level), 0);
    step('1, 1'b0, 1'b0);
    chk("post_flush_grant", int'(obs_ready), PRIO ? 1 : 4);

    // Underflow at level 0, sticky until flush
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    chk("uf_set", int'(underflow), 1);
    chk("uf_level", int'(level), 0);
    step('0, 1'b0, 1'b0);
    chk("uf_held", int'(underflow), 1);

    // Fill to capacity from requester 2
    for (int k = 0; k < 7; k++) step(4'b0100, 1'b0, 1'b0);
    chk("fill_level", int'(level), 7);
    chk("fill_full", int'(full), 1);
    step(4'b0100, 1'b0, 1'b0);
    chk("full_no_ready", int'(obs_ready), 0);
    step(4'b0100, 1'b0, 1'b1);
    chk("full_rd_ready", int'(obs_ready), 0);
    chk("full_rd_level", int'(level), 6);
    step(4'b0100, 1'b0, 1'b0);
    chk("one_more_acc", int'(obs_ready), 4);
    step(4'b0100, 1'b0, 1'b0);
    chk("full_again", int'(obs_ready), 0);
    chk("uf_still", int'(underflow), 1);

    // Requesters 0 and 1 contending
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0011, 1'b0, 1'b0);
      chk("pair_grant", int'(obs_ready), PRIO ? 1 : ((k % 2 == 0) ? 1 : 2));
    end

    // Asynchronous reset mid-burst
    for (int i = 0; i < NREQ; i++) dat[i] = 8'($urandom);
    repeat (3) step('1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ready", int'(req_ready), 0);
    chk("arst_strobe", int'(fifo_write_strobe), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_gid", int'(grant_id), 0);
    chk("arst_clear", int'(fifo_clear), 0);
    chk("arst_uf", int'(underflow), 0);
    chk("arst_data", int'(fifo_write_data), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step('1, 1'b0, 1'b0);
    chk("arst_first_grant", int'(obs_ready), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) dat[i] = 8'($urandom);
      step(4'($urandom), ($urandom % 20) == 0, ($urandom % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
